stream_extrema_reducer: RTL and testbench

//   Streaming reducer over frames of LEN signed-magnitude fixed-point samples (sign bit
//   N-1, 1 = negative; magnitude N-2:0 with Q fraction bits). Returns the frame maximum,
//   the frame minimum and the index of each.

---
 rtl/stream_extrema_reducer.sv | 111 +++++++++++
 tb/tb_stream_extrema_reducer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_extrema_reducer.sv
// Streaming frame reducer: returns max/min (with their indices) of each LEN-sample frame of
// signed-magnitude values, held on a valid/ready output until accepted.
module stream_extrema_reducer #(
    parameter int unsigned Q   = 16,
    parameter int unsigned N   = 32,
    parameter int unsigned LEN = 4,
    localparam int unsigned IW = $clog2(LEN > 1 ? LEN : 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_max,
    output logic [IW-1:0] out_max_idx,
    output logic [N-1:0]  out_min,
    output logic [IW-1:0] out_min_idx
);

    // Q only documents the fixed-point format; ordering is independent of it.
    if (Q >= N || LEN < 1) begin : g_param_check
        $error("stream_extrema_reducer: need Q < N and LEN >= 1");
    end

    localparam logic [IW-1:0] LastIdx = IW'(LEN - 1);

    typedef enum logic {StAccum, StHold} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] count_q, count_d;
    logic [N-1:0]  max_q, max_d, min_q, min_d;
    logic [IW-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;

    // Two's-complement view of a signed-magnitude sample; -0 maps to 0 so it ties with +0.
    function automatic logic signed [N-1:0] true_val(input logic [N-1:0] s);
        logic signed [N-1:0] m;
        m = $signed({1'b0, s[N-2:0]});
        return s[N-1] ? -m : m;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StAccum;
            count_q   <= '0;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        unique case (state_q)
            StAccum: begin
                if (in_valid) begin
                    if (count_q == '0) begin
                        max_d     = in_data;
                        min_d     = in_data;
                        max_idx_d = '0;
                        min_idx_d = '0;
                    end else begin
                        // Strict compares so ties keep the earlier sample.
                        if (true_val(in_data) > true_val(max_q)) begin
                            max_d     = in_data;
                            max_idx_d = count_q;
                        end
                        if (true_val(in_data) < true_val(min_q)) begin
                            min_d     = in_data;
                            min_idx_d = count_q;
                        end
                    end
                    if (count_q == LastIdx) begin
                        count_d = '0;
                        state_d = StHold;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    assign in_ready    = (state_q == StAccum);
    assign out_valid   = (state_q == StHold);
    assign out_max     = max_q;
    assign out_min     = min_q;
    assign out_max_idx = max_idx_q;
    assign out_min_idx = min_idx_q;

endmodule

// File: tb/tb_stream_extrema_reducer.sv
// Bench: directed frames plus randomized streams on LEN=4 and LEN=1 instances, scored
// against a frame-level reference model.
module tb_stream_extrema_reducer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic check_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // LEN=4 instance
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_max, a_out_min;
    logic [1:0]  a_max_idx, a_min_idx;
    // LEN=1 instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_max, b_out_min;
    logic [0:0]  b_max_idx, b_min_idx;

    stream_extrema_reducer #(.Q(16), .N(32), .LEN(4)) u_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_max(a_out_max), .out_max_idx(a_max_idx),
        .out_min(a_out_min), .out_min_idx(a_min_idx)
    );

    stream_extrema_reducer #(.Q(16), .N(32), .LEN(1)) u_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_max(b_out_max), .out_max_idx(b_max_idx),
        .out_min(b_out_min), .out_min_idx(b_min_idx)
    );

    typedef struct {
        logic [31:0] mx;
        int          mxi;
        logic [31:0] mn;
        int          mni;
    } res_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint value_of(input logic [31:0] x);
        return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
    endfunction

    function automatic res_t reduce(input logic [31:0] f[$]);
        res_t r;
        r.mx = f[0]; r.mxi = 0; r.mn = f[0]; r.mni = 0;
        for (int i = 1; i < f.size(); i++) begin
            if (value_of(f[i]) > value_of(r.mx)) begin r.mx = f[i]; r.mxi = i; end
            if (value_of(f[i]) < value_of(r.mn)) begin r.mn = f[i]; r.mni = i; end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_sample();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: v = {v[31], 29'd0, v[1:0]};
            1: v = {v[31], 31'd0};
            default: ;
        endcase
        return v;
    endfunction

    // Reference model: collect frames, reduce when complete, retire on output handshake.
    logic [31:0] a_frame[$];
    logic [31:0] b_frame[$];
    res_t        a_exp[$];
    res_t        b_exp[$];
    int          a_done = 0;
    int          b_done = 0;

    always @(posedge clk) begin
        if (reset) begin
            a_frame.delete(); a_exp.delete();
            b_frame.delete(); b_exp.delete();
        end else begin
            if (a_exp.size() > 0) begin
                if (a_out_ready) begin void'(a_exp.pop_front()); a_done++; end
            end else if (a_in_valid) begin
                a_frame.push_back(a_in_data);
                if (a_frame.size() == 4) begin a_exp.push_back(reduce(a_frame)); a_frame.delete(); end
            end
            if (b_exp.size() > 0) begin
                if (b_out_ready) begin void'(b_exp.pop_front()); b_done++; end
            end else if (b_in_valid) begin
                b_frame.push_back(b_in_data);
                b_exp.push_back(reduce(b_frame));
                b_frame.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (check_en && !reset) begin
            check("a_out_valid", 64'(a_out_valid), 64'(a_exp.size() > 0));
            check("a_in_ready", 64'(a_in_ready), 64'(a_exp.size() == 0));
            if (a_exp.size() > 0) begin
                check("a_max", 64'(a_out_max), 64'(a_exp[0].mx));
                check("a_max_idx", 64'(a_max_idx), 64'(a_exp[0].mxi));
                check("a_min", 64'(a_out_min), 64'(a_exp[0].mn));
                check("a_min_idx", 64'(a_min_idx), 64'(a_exp[0].mni));
            end
            check("b_out_valid", 64'(b_out_valid), 64'(b_exp.size() > 0));
            check("b_in_ready", 64'(b_in_ready), 64'(b_exp.size() == 0));
            if (b_exp.size() > 0) begin
                check("b_max", 64'(b_out_max), 64'(b_exp[0].mx));
                check("b_max_idx", 64'(b_max_idx), 64'(b_exp[0].mxi));
                check("b_min", 64'(b_out_min), 64'(b_exp[0].mn));
                check("b_min_idx", 64'(b_min_idx), 64'(b_exp[0].mni));
            end
        end
    end

    task automatic a_send(input logic [31:0] d);
        a_in_valid = 1'b1;
        a_in_data  = d;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic a_expect(input string name, input logic [31:0] mx, input int mxi,
                            input logic [31:0] mn, input int mni);
        int n = 0;
        while (!a_out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check({name, "_valid"}, 64'(a_out_valid), 64'd1);
        check({name, "_max"}, 64'(a_out_max), 64'(mx));
        check({name, "_max_idx"}, 64'(a_max_idx), 64'(mxi));
        check({name, "_min"}, 64'(a_out_min), 64'(mn));
        check({name, "_min_idx"}, 64'(a_min_idx), 64'(mni));
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check({name, "_released"}, 64'(a_out_valid), 64'd0);
        check({name, "_in_ready"}, 64'(a_in_ready), 64'd1);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_a_valid"}, 64'(a_out_valid), 64'd0);
        check({name, "_a_in_ready"}, 64'(a_in_ready), 64'd1);
        check({name, "_a_fields"}, {a_out_max, a_out_min}, 64'd0);
        check({name, "_a_idx"}, 64'({a_max_idx, a_min_idx}), 64'd0);
    endtask

    initial begin
        int cyc;
        logic acc;
        reset = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        check("reset_b_fields", {b_out_max, b_out_min}, 64'd0);
        check("reset_b_valid", 64'(b_out_valid), 64'd0);
        reset = 1'b0;
        check_en = 1'b1;
        @(posedge clk); #1;

        // 1: mixed signs, result visible the cycle after the 4th accept
        a_send(32'h0001_8000); a_send(32'h8002_0000); a_send(32'h0003_4000); a_send(32'h0000_8000);
        check("t1_latency", 64'(a_out_valid), 64'd1);
        a_expect("t1", 32'h0003_4000, 2, 32'h8002_0000, 1);

        // 2: all negative, tie on -4.0 keeps index 1
        a_send(32'h8001_0000); a_send(32'h8004_0000); a_send(32'h8000_4000); a_send(32'h8004_0000);
        a_expect("t2", 32'h8000_4000, 2, 32'h8004_0000, 1);

        // 3: +0 and -0 compare equal, first +0 wins both
        a_send(32'h0000_0000); a_send(32'h8000_0000); a_send(32'h0000_0000); a_send(32'h8000_0000);
        a_expect("t3", 32'h0000_0000, 0, 32'h0000_0000, 0);

        // 4: backpressure in HOLD with a sample pending upstream
        a_send(32'h0001_8000); a_send(32'h8002_0000); a_send(32'h0003_4000); a_send(32'h0000_8000);
        a_in_valid = 1'b1;
        a_in_data  = 32'h7fff_ffff;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_in_ready", 64'(a_in_ready), 64'd0);
            check("t4_hold_max", 64'(a_out_max), 64'h0003_4000);
            check("t4_hold_min", 64'(a_out_min), 64'h8002_0000);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        check("t4_release", 64'(a_in_ready), 64'd1);
        a_send(32'h8001_0000); a_send(32'h8004_0000); a_send(32'h8000_4000); a_send(32'h8004_0000);
        a_expect("t4_next", 32'h8000_4000, 2, 32'h8004_0000, 1);

        // 5: reset mid-frame drops the partial frame
        a_send(32'h7000_0000); a_send(32'h8700_0000);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_values("t5_reset");
        a_send(32'h0007_0000); a_send(32'h0001_0000); a_send(32'h0002_0000); a_send(32'h0003_0000);
        a_expect("t5", 32'h0007_0000, 0, 32'h0001_0000, 1);

        // Random frames on LEN=4 with valid gaps and backpressure
        a_done = 0;
        cyc = 0;
        while (a_done < 30 && cyc < 4000) begin
            acc = a_in_valid && a_in_ready;
            @(posedge clk); #1;
            if (!a_in_valid || acc) begin
                a_in_valid = ($urandom_range(0, 3) != 0);
                a_in_data  = rand_sample();
            end
            a_out_ready = $urandom_range(0, 1) == 1;
            cyc++;
        end
        check("a_random_done", 64'(a_done >= 30), 64'd1);
        a_in_valid = 1'b0;

        // 6: LEN=1, 100 samples with random gaps
        b_done = 0;
        cyc = 0;
        while (b_done < 100 && cyc < 4000) begin
            acc = b_in_valid && b_in_ready;
            @(posedge clk); #1;
            if (!b_in_valid || acc) begin
                b_in_valid = ($urandom_range(0, 2) != 0);
                b_in_data  = rand_sample();
            end
            b_out_ready = $urandom_range(0, 2) != 0;
            cyc++;
        end
        check("b_random_done", 64'(b_done >= 100), 64'd1);
        b_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
